// File: rtl/keccak_pad_feeder.sv
// Feeds 64-bit message lanes into the SHAKE128 SIPO loader, applying Keccak
// multi-rate padding and emitting exactly RATE_WORDS lanes per block.
module keccak_pad_feeder #(
  parameter int unsigned RATE_WORDS = 21,
  parameter logic [7:0]  DOMAIN_PAD = 8'h1F,
  parameter int unsigned DATA_SIZE  = 64
) (
  input  logic                 clk,
  input  logic                 hash_init,
  input  logic [DATA_SIZE-1:0] msg_data,
  input  logic                 msg_valid,
  input  logic                 msg_last,
  input  logic [3:0]           msg_bytes,
  output logic                 msg_ready,
  input  logic                 perm_done,
  output logic [DATA_SIZE-1:0] word_out,
  output logic                 load_en,
  output logic                 cntr_zero,
  output logic                 last_block,
  output logic                 pad_done
);

  localparam int unsigned CNT_W  = $clog2(RATE_WORDS);
  localparam int unsigned NBYTES = DATA_SIZE / 8;
  localparam logic [CNT_W-1:0]     LAST_LANE = CNT_W'(RATE_WORDS - 1);
  localparam logic [DATA_SIZE-1:0] END_BIT   = {1'b1, {(DATA_SIZE-1){1'b0}}};
  localparam logic [DATA_SIZE-1:0] PAD_LANE  = DATA_SIZE'(DOMAIN_PAD);

  typedef enum logic [1:0] {
    S_MSG  = 2'd0,
    S_PAD  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     lane_cnt_q, lane_cnt_d;
  logic                 pad_pending_q, pad_pending_d;
  logic                 final_q, final_d;
  logic [DATA_SIZE-1:0] word_d;
  logic                 load_d, cz_d, lb_d, pad_done_d;

  logic                 accept_c;
  logic                 last_lane_c;
  logic [3:0]           nbytes_c;
  logic [DATA_SIZE-1:0] padded_c;

  assign msg_ready   = (state_q == S_MSG) && !hash_init;
  assign accept_c    = msg_valid && msg_ready;
  assign last_lane_c = (lane_cnt_q == LAST_LANE);
  // Byte counts above a full word are clamped to a full word.
  assign nbytes_c    = (msg_bytes > 4'd8) ? 4'd8 : msg_bytes;

  // Last partial word: keep bytes below n, place the domain byte at n, zero the rest.
  always_comb begin
    padded_c = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (4'(i) < nbytes_c) begin
        padded_c[8*i +: 8] = msg_data[8*i +: 8];
      end else if (4'(i) == nbytes_c) begin
        padded_c[8*i +: 8] = DOMAIN_PAD;
      end
    end
  end

  // Next-state and emission logic.
  always_comb begin
    state_d       = state_q;
    lane_cnt_d    = lane_cnt_q;
    pad_pending_d = pad_pending_q;
    final_d       = final_q;
    word_d        = word_out;
    load_d        = 1'b0;
    cz_d          = 1'b0;
    lb_d          = 1'b0;
    pad_done_d    = pad_done;

    unique case (state_q)
      S_MSG: begin
        if (accept_c) begin
          load_d     = 1'b1;
          cz_d       = last_lane_c;
          lane_cnt_d = last_lane_c ? '0 : lane_cnt_q + CNT_W'(1);
          if (msg_last && (nbytes_c != 4'd8)) begin
            word_d = padded_c | (last_lane_c ? END_BIT : '0);
            if (last_lane_c) begin
              final_d = 1'b1;
              lb_d    = 1'b1;
              state_d = S_WAIT;
            end else begin
              state_d = S_PAD;
            end
          end else begin
            word_d = msg_data;
            if (msg_last) begin
              pad_pending_d = 1'b1;
            end
            if (last_lane_c) begin
              state_d = S_WAIT;
            end else if (msg_last) begin
              state_d = S_PAD;
            end
          end
        end
      end

      S_PAD: begin
        load_d        = 1'b1;
        cz_d          = last_lane_c;
        lane_cnt_d    = last_lane_c ? '0 : lane_cnt_q + CNT_W'(1);
        word_d        = pad_pending_q ? PAD_LANE : '0;
        pad_pending_d = 1'b0;
        // Padding always closes in this block, so its last lane ends the hash input.
        if (last_lane_c) begin
          word_d  = word_d | END_BIT;
          final_d = 1'b1;
          lb_d    = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (perm_done) begin
          if (final_q) begin
            state_d    = S_DONE;
            pad_done_d = 1'b1;
          end else begin
            state_d = pad_pending_q ? S_PAD : S_MSG;
          end
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_MSG;
      end
    endcase
  end

  // State and registered outputs; hash_init also discards any partial block.
  always_ff @(posedge clk) begin
    if (hash_init) begin
      state_q       <= S_MSG;
      lane_cnt_q    <= '0;
      pad_pending_q <= 1'b0;
      final_q       <= 1'b0;
      word_out      <= '0;
      load_en       <= 1'b0;
      cntr_zero     <= 1'b0;
      last_block    <= 1'b0;
      pad_done      <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_cnt_q    <= lane_cnt_d;
      pad_pending_q <= pad_pending_d;
      final_q       <= final_d;
      word_out      <= word_d;
      load_en       <= load_d;
      cntr_zero     <= cz_d;
      last_block    <= lb_d;
      pad_done      <= pad_done_d;
    end
  end

endmodule

// File: tb/tb_keccak_pad_feeder.sv
// Random-stimulus bench for keccak_pad_feeder against a padded-byte-stream
// reference model, plus literal lane checks for the directed messages.
module tb_keccak_pad_feeder;

  localparam int RATE  = 21;
  localparam int BLK_B = RATE * 8;

  logic        clk = 1'b0;
  logic        hash_init = 1'b1;
  logic [63:0] msg_data = '0;
  logic        msg_valid = 1'b0;
  logic        msg_last = 1'b0;
  logic [3:0]  msg_bytes = '0;
  logic        msg_ready;
  logic        perm_done = 1'b0;
  logic [63:0] word_out;
  logic        load_en;
  logic        cntr_zero;
  logic        last_block;
  logic        pad_done;

  always #5 clk = ~clk;

  keccak_pad_feeder dut (
    .clk        (clk),
    .hash_init  (hash_init),
    .msg_data   (msg_data),
    .msg_valid  (msg_valid),
    .msg_last   (msg_last),
    .msg_bytes  (msg_bytes),
    .msg_ready  (msg_ready),
    .perm_done  (perm_done),
    .word_out   (word_out),
    .load_en    (load_en),
    .cntr_zero  (cntr_zero),
    .last_block (last_block),
    .pad_done   (pad_done)
  );

  typedef struct packed {
    logic [63:0] word;
    logic        cz;
    logic        lb;
  } lane_t;

  lane_t       exp_q[$];
  logic [63:0] msg_words[$];
  logic [63:0] got_lane[RATE];
  int          blk_lane = 0;
  logic [63:0] prev_word = '0;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: message bytes, domain byte, zero fill to a block multiple, 0x80 on the final byte.
  task automatic build_expected(input int nb);
    logic [7:0]  b[$];
    logic [63:0] w;
    lane_t       e;
    int          n, len, nl;
    n   = (nb > 8) ? 8 : nb;
    len = 8 * (msg_words.size() - 1) + n;
    for (int j = 0; j < len; j++) begin
      w = msg_words[j / 8];
      b.push_back(8'(w >> (8 * (j % 8))));
    end
    b.push_back(8'h1F);
    while ((b.size() % BLK_B) != 0) b.push_back(8'h00);
    b[b.size() - 1] = b[b.size() - 1] | 8'h80;
    nl = b.size() / 8;
    for (int l = 0; l < nl; l++) begin
      w = '0;
      for (int m = 0; m < 8; m++) w = w | (64'(b[8 * l + m]) << (8 * m));
      e.word = w;
      e.cz   = ((l % RATE) == RATE - 1);
      e.lb   = (l == nl - 1);
      exp_q.push_back(e);
    end
  endtask

  // Per-cycle comparison of every emitted lane against the model queue.
  initial begin
    lane_t e;
    forever begin
      @(negedge clk);
      if (load_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_load_en", 64'(load_en), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("word_out", word_out, e.word);
          check("cntr_zero", 64'(cntr_zero), 64'(e.cz));
          check("last_block", 64'(last_block), 64'(e.lb));
        end
        got_lane[blk_lane] = word_out;
        blk_lane  = (blk_lane == RATE - 1) ? 0 : blk_lane + 1;
        prev_word = word_out;
      end else begin
        check("idle_flags", 64'({cntr_zero, last_block}), 64'd0);
        check("word_hold", word_out, prev_word);
      end
      check("pad_done_early", 64'(pad_done && (exp_q.size() != 0)), 64'd0);
      if (hash_init) begin
        blk_lane  = 0;
        prev_word = '0;
      end
    end
  end

  // Permutation stand-in: acks each block after a random delay, spurious pulses otherwise.
  initial begin
    bit waiting = 1'b0;
    int delay = 0;
    forever begin
      @(posedge clk);
      #2;
      if (hash_init) begin
        waiting   = 1'b0;
        perm_done = 1'b0;
      end else if (load_en && cntr_zero) begin
        waiting   = 1'b1;
        delay     = int'($urandom_range(0, 4));
        perm_done = 1'b0;
      end else if (waiting) begin
        if (delay == 0) begin
          perm_done = 1'b1;
          waiting   = 1'b0;
        end else begin
          delay--;
          perm_done = 1'b0;
        end
      end else begin
        perm_done = ($urandom_range(0, 7) == 0);
      end
    end
  end

  task automatic do_reset();
    hash_init = 1'b1;
    @(posedge clk);
    #1;
    hash_init = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_word_out", word_out, 64'd0);
    check("rst_flags", 64'({load_en, cntr_zero, last_block, pad_done}), 64'd0);
    check("rst_msg_ready", 64'(msg_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Drives k words; mode 0 = random valid gaps, mode 1 = valid toggling every cycle.
  task automatic send_msg(input int k, input int nb, input int mode, input int abort_after,
                          input bit use_fixed, input logic [63:0] fixed);
    int i, cyc;
    bit acc;
    msg_words.delete();
    for (int j = 0; j < k; j++) msg_words.push_back(use_fixed ? fixed : {$urandom, $urandom});
    build_expected(nb);
    i   = 0;
    cyc = 0;
    while (i < k && cyc < 4000) begin
      msg_data  = msg_words[i];
      msg_last  = (i == k - 1);
      msg_bytes = msg_last ? 4'(nb) : 4'($urandom_range(0, 15));
      msg_valid = (mode == 0) ? ($urandom_range(0, 3) != 0) : ((cyc % 2) == 0);
      @(negedge clk);
      acc = msg_valid && msg_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) i++;
      if (abort_after >= 0 && i == abort_after) break;
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    check("accept_timeout", 64'(cyc >= 4000), 64'd0);
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!pad_done && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("pad_done", 64'(pad_done), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("ready_in_done", 64'(msg_ready), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Empty message.
    send_msg(1, 0, 0, -1, 1'b1, 64'hDEAD_BEEF_0BAD_F00D);
    wait_done();
    check("empty_lane0", got_lane[0], 64'h0000_0000_0000_001F);
    check("empty_lane20", got_lane[20], 64'h8000_0000_0000_0000);

    // One byte 0xAB with garbage above it.
    do_reset();
    send_msg(1, 1, 0, -1, 1'b1, 64'hFFFF_FFFF_FFFF_FFAB);
    wait_done();
    check("byte_lane0", got_lane[0], 64'h0000_0000_0000_1FAB);
    check("byte_lane20", got_lane[20], 64'h8000_0000_0000_0000);

    // Domain and final pad bits share the last byte.
    do_reset();
    send_msg(21, 7, 0, -1, 1'b1, 64'h1111_1111_1111_1111);
    wait_done();
    check("b7_lane20", got_lane[20], 64'h9F11_1111_1111_1111);

    // Exactly one full block of message: padding spills into a second block.
    do_reset();
    send_msg(21, 8, 0, -1, 1'b1, 64'h2222_2222_2222_2222);
    wait_done();
    check("spill_lane0", got_lane[0], 64'h0000_0000_0000_001F);
    check("spill_lane20", got_lane[20], 64'h8000_0000_0000_0000);

    // Valid toggling every cycle across a block.
    do_reset();
    send_msg(21, 3, 1, -1, 1'b0, '0);
    wait_done();

    // Reset after 10 lanes, then a fresh one-byte message.
    do_reset();
    send_msg(21, 3, 0, 10, 1'b0, '0);
    do_reset();
    send_msg(1, 1, 0, -1, 1'b1, 64'h0123_4567_89AB_CD5A);
    wait_done();
    check("rst_lane0", got_lane[0], 64'h0000_0000_0000_1F5A);

    // Random lengths, byte counts (including >8) and valid patterns.
    for (int t = 0; t < 10; t++) begin
      do_reset();
      send_msg(int'($urandom_range(1, 60)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 1)), -1, 1'b0, '0);
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/keccak_pad_feeder.md
Name: keccak_pad_feeder

Overview:
- Upstream stage of the 1344-bit SIPO block loader (SHAKE128 rate, 21 x 64-bit lanes).
- Accepts the message as 64-bit little-endian words over a valid/ready handshake and applies Keccak multi-rate padding (domain byte, zero fill, final 0x80).
- Emits exactly 21 words per block, with load_en and cntr_zero, into the SIPO data_in/load_en/cntr_zero inputs.
- Stalls at each block boundary until the permutation signals it has consumed the block.

Parameters:
- RATE_WORDS, 21, lanes per block; cntr_zero marks lane index RATE_WORDS-1.
- DOMAIN_PAD, 8'h1F, first padding byte (domain suffix plus first pad bit).
- DATA_SIZE, 64, lane width in bits; fixed at 64.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- hash_init  in  1  reset, synchronous, active-high; also starts a new hash.
- msg_data  in  64  message word; byte i at bits [8i+7:8i].
- msg_valid  in  1  msg_data, msg_last and msg_bytes are valid.
- msg_last  in  1  current word is the final message word.
- msg_bytes  in  4  valid bytes in the last word, 0..8; sampled only with msg_last.
- msg_ready  out  1  feeder accepts a word this cycle.
- perm_done  in  1  one-cycle pulse: previous block absorbed, next block may load.
- word_out  out  64  lane to SIPO data_in.
- load_en  out  1  word_out valid; one pulse per lane.
- cntr_zero  out  1  high with load_en on lane RATE_WORDS-1.
- last_block  out  1  high with cntr_zero of the final padded block.
- pad_done  out  1  sticky; final block fully emitted.

Behaviour:
- Reset, synchronous: on any clk edge with hash_init=1, state=MSG, lane_cnt=0, pad_pending=0, and all registered outputs are 0 (word_out, load_en, cntr_zero, last_block, pad_done). This applies mid-block too; a partial block is discarded.
- msg_ready is combinational: it equals (state==MSG && !hash_init).
- A word is accepted when msg_valid && msg_ready.
- Latency: an accepted or padded lane appears on word_out with load_en=1 exactly one cycle later.
- load_en=0 on any cycle without emission. word_out holds its previous value then.
- lane_cnt (0..20) increments on each emitted lane and wraps to 0 after lane 20. Lane 20 asserts cntr_zero, and the FSM then enters WAIT.
- States:
  - MSG: accept words.
    - Non-last word: emitted unchanged.
    - Last word with n=msg_bytes<8: bytes >= n are zeroed and byte n = DOMAIN_PAD. If this is lane 20, byte 7 is ORed with 0x80 (n=7 gives 0x9F); the block is final and the FSM goes to WAIT. Otherwise the FSM goes to PAD.
    - Last word with n=8: emitted unchanged and pad_pending=1. The next state is PAD, or WAIT if it was lane 20.
    - n=0 emits DOMAIN_PAD in byte 0. An empty message is a single msg_last word with n=0.
  - PAD: msg_ready=0; one lane per cycle, no input.
    - Lane content is 0. If pad_pending, byte 0 = DOMAIN_PAD and pad_pending then clears.
    - Lane 20 ORs 0x80 into byte 7 and goes to WAIT with the block marked final.
  - WAIT: no emission; perm_done is sampled only here.
    - On perm_done with the block final: go to DONE and set pad_done=1.
    - On perm_done otherwise: go to PAD if pad_pending, else MSG.
    - perm_done in any other state is ignored.
  - DONE: msg_ready=0, no emission; held until hash_init.
- last_block=1 with load_en and cntr_zero on lane 20 of the final block only.
- msg_bytes>8 is illegal and is treated as 8.
- msg_valid dropping mid-block leaves no bubbles in the output count; lanes are still exactly 21 per block.

Test Plan:
- Empty message: hash_init, then accept {last=1, bytes=0} -> lane0=0x000000000000001F, lanes1..19=0, lane20=0x8000000000000000 with cntr_zero=1, last_block=1; after perm_done, pad_done=1.
- One byte 0xAB (bytes=1, data=0x...FFAB) -> lane0=0x0000000000001FAB, upper garbage masked; lane20=0x8000000000000000.
- 20 full words + last with bytes=7 (data 0x11..11) -> lane20=0x9F11111111111111, cntr_zero=1, last_block=1, no second block.
- 21 full words, last bytes=8 -> block 1 is lanes as given, last_block=0; msg_ready=0 until perm_done; block 2 has lane0=0x1F, lane20=0x8000000000000000, last_block=1.
- Stall: msg_valid toggles 1/0 over 21 words -> exactly 21 load_en pulses, cntr_zero only on the 21st; perm_done pulsed in MSG is ignored.
- Reset mid-block: hash_init after 10 lanes -> next cycle all outputs 0, msg_ready=1; a new 1-byte message yields a correctly padded block with lane_cnt starting at 0.
